// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port round-robin arbiter with bounded port-1 lock for the 32x8 core memory
// Optional: define ARB_WRITE_PROTECT_EN to block port-0 writes to the program region (addresses 0..15).
module mem_port_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          locked
`ifdef ARB_WRITE_PROTECT_EN
  ,
  output logic          wp_err
`endif
);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  state_t        r_state, w_state_nxt;
  logic          r_rr_ptr, w_rr_nxt;
  logic [7:0]    r_lock_cnt, w_lock_cnt_nxt;
  logic          w_gnt0, w_gnt1;
  logic          w_wp_block;
  logic          r_rv0, r_rv1;
  logic          w_rv0, w_rv1;
  logic [DW-1:0] r_hold0, r_hold1;

  always_comb begin
    w_gnt0         = 1'b0;
    w_gnt1         = 1'b0;
    w_state_nxt    = r_state;
    w_rr_nxt       = r_rr_ptr;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      S_IDLE: begin
        if (m0_req && m1_req) begin
          w_gnt0 = ~r_rr_ptr;
          w_gnt1 = r_rr_ptr;
        end else begin
          w_gnt0 = m0_req;
          w_gnt1 = m1_req;
        end
        if (w_gnt0) w_rr_nxt = 1'b1;
        if (w_gnt1) begin
          w_rr_nxt = 1'b0;
          if (m1_lock) begin
            w_state_nxt    = S_LOCK;
            w_lock_cnt_nxt = 8'd1;
          end
        end
      end
      S_LOCK: begin
        // Loader owns the memory; the grant at lock_cnt==MAX_LOCK is its last one.
        w_gnt1 = m1_req;
        if (m1_req && m1_lock) w_lock_cnt_nxt = r_lock_cnt + 8'd1;
        if (!m1_lock || !m1_req || (r_lock_cnt == LOCK_MAX)) begin
          w_state_nxt    = S_IDLE;
          w_rr_nxt       = 1'b0;
          w_lock_cnt_nxt = 8'd0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!rst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

`ifdef ARB_WRITE_PROTECT_EN
  localparam logic [AW:0] WP_LIMIT = (AW+1)'(16);
  assign w_wp_block = w_gnt0 & m0_we & ({1'b0, m0_addr} < WP_LIMIT);
`else
  assign w_wp_block = 1'b0;
`endif

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt0 && !w_wp_block) begin
      mem_en    = 1'b1;
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (w_gnt1) begin
      mem_en    = 1'b1;
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 1'b0;
      r_lock_cnt <= 8'd0;
      r_rv0      <= 1'b0;
      r_rv1      <= 1'b0;
      r_hold0    <= '0;
      r_hold1    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_rv0      <= w_gnt0 & ~m0_we;
      r_rv1      <= w_gnt1 & ~m1_we;
      if (r_rv0) r_hold0 <= mem_rdata;
      if (r_rv1) r_hold1 <= mem_rdata;
    end
  end

`ifdef ARB_WRITE_PROTECT_EN
  logic r_wp_err;
  always_ff @(posedge clk) begin
    if (!rst_n) r_wp_err <= 1'b0;
    else        r_wp_err <= r_wp_err | w_wp_block;
  end
  assign wp_err = r_wp_err;
`endif

  // A read completing as reset asserts is dropped; the requester reissues it.
  assign w_rv0     = r_rv0 & rst_n;
  assign w_rv1     = r_rv1 & rst_n;
  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = w_rv0;
  assign m1_rvalid = w_rv1;
  assign m0_rdata  = w_rv0 ? mem_rdata : r_hold0;
  assign m1_rdata  = w_rv1 ? mem_rdata : r_hold1;
  assign locked    = (r_state == S_LOCK);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector table plus read-data scoreboard for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int MAX_LOCK = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_en, mem_we, locked;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef ARB_WRITE_PROTECT_EN
  logic          wp_err;
`endif

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .locked(locked)
`ifdef ARB_WRITE_PROTECT_EN
    , .wp_err(wp_err)
`endif
  );

  logic [DW-1:0] mem    [32];
  logic [DW-1:0] shadow [32];

  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic rst;
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, lk, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic eg0, eg1, elk;
  } vec_t;

  vec_t          tbl[$];
  logic [DW-1:0] q0[$], q1[$];
  logic [DW-1:0] hold0, hold1;
  logic          exp_wp;
  int            n_checks = 0;
  int            n_err = 0;

  function automatic vec_t mk(int rst, int r0, int w0, int a0, int d0,
                              int r1, int lk, int w1, int a1, int d1,
                              int eg0, int eg1, int elk);
    vec_t v;
    v.rst = (rst != 0); v.r0 = (r0 != 0); v.w0 = (w0 != 0);
    v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.r1 = (r1 != 0); v.lk = (lk != 0); v.w1 = (w1 != 0);
    v.a1 = AW'(a1); v.d1 = DW'(d1);
    v.eg0 = (eg0 != 0); v.eg1 = (eg1 != 0); v.elk = (elk != 0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic          blk, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e;
    @(negedge clk);
    rst_n = ~v.rst;
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_lock = v.lk; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    #1;
    if (v.rst) begin q0.delete(); q1.delete(); end
`ifdef ARB_WRITE_PROTECT_EN
    blk = v.eg0 && v.w0 && (v.a0 < AW'(16));
`else
    blk = 1'b0;
`endif
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (v.eg0 && !blk) begin e_en = 1'b1; e_we = v.w0; e_addr = v.a0; e_wd = v.d0; end
    else if (v.eg1)    begin e_en = 1'b1; e_we = v.w1; e_addr = v.a1; e_wd = v.d1; end
    chk($sformatf("v%0d m0_gnt", idx), 32'(m0_gnt), 32'(v.eg0));
    chk($sformatf("v%0d m1_gnt", idx), 32'(m1_gnt), 32'(v.eg1));
    chk($sformatf("v%0d locked", idx), 32'(locked), 32'(v.elk));
    chk($sformatf("v%0d mem_en", idx), 32'(mem_en), 32'(e_en));
    chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(e_we));
    chk($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(e_addr));
    chk($sformatf("v%0d mem_wdata", idx), 32'(mem_wdata), 32'(e_wd));
`ifdef ARB_WRITE_PROTECT_EN
    chk($sformatf("v%0d wp_err", idx), 32'(wp_err), 32'(exp_wp));
`endif
    chk($sformatf("v%0d m0_rvalid", idx), 32'(m0_rvalid), 32'(q0.size() != 0));
    if (q0.size() != 0) begin e = q0.pop_front(); hold0 = e; end
    chk($sformatf("v%0d m0_rdata", idx), 32'(m0_rdata), 32'(hold0));
    chk($sformatf("v%0d m1_rvalid", idx), 32'(m1_rvalid), 32'(q1.size() != 0));
    if (q1.size() != 0) begin e = q1.pop_front(); hold1 = e; end
    chk($sformatf("v%0d m1_rdata", idx), 32'(m1_rdata), 32'(hold1));
    if (v.eg0 && !v.w0) q0.push_back(shadow[v.a0]);
    if (v.eg0 && v.w0 && !blk) shadow[v.a0] = v.d0;
    if (v.eg1 && !v.w1) q1.push_back(shadow[v.a1]);
    if (v.eg1 && v.w1) shadow[v.a1] = v.d1;
    if (blk) exp_wp = 1'b1;
    if (v.rst) begin hold0 = '0; hold1 = '0; exp_wp = 1'b0; end
  endtask

  initial begin
    int denied, nlocked;
    logic seen;
    for (int i = 0; i < 32; i++) begin
      mem[i] = DW'(i * 7 + 17);
      shadow[i] = DW'(i * 7 + 17);
    end
    mem[5] = 8'h3C; shadow[5] = 8'h3C;
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    hold0 = '0; hold1 = '0; exp_wp = 1'b0;
    repeat (2) @(posedge clk);

    //                 rst r0 w0 a0 d0     r1 lk w1 a1 d1     g0 g1 lk
    tbl.push_back(mk(1, 1, 0, 5, 0,      1, 0, 0, 9, 0,      0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 5, 0,      0, 0, 0, 0, 0,      1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 1, 0, 2, 0,    1, 0, 0, 9, 0,      (k % 2 == 0), (k % 2 == 1), 0));
    tbl.push_back(mk(0, 1, 1, 3, 'hAA,   0, 0, 0, 0, 0,      1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 20, 'h55,  0, 0, 0, 0, 0,      1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0, 3, 0,      0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 20, 0,     0, 0, 0, 0, 0,      1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 1, 0, 9, 0,      0, 1, 0));
    for (int k = 0; k < MAX_LOCK; k++)
      tbl.push_back(mk(0, 1, 0, 2, 0,    1, 1, 0, 9, 0,      0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 1, 0, 9, 0,      1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 1, 0, 9, 0,      0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 1, 0, 9, 0,      0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 1, 0, 9, 0,      0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 0, 0, 9, 0,      0, 1, 1));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 0, 0, 9, 0,      1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 1, 0, 9, 0,      0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0,      0, 0, 0, 0, 0,      0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 0, 0, 9, 0,      1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 1, 0, 9, 0,      0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 1, 0, 9, 0,      0, 1, 1));
    tbl.push_back(mk(1, 1, 0, 2, 0,      1, 1, 0, 9, 0,      0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 0, 0, 9, 0,      1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 0,      1, 0, 0, 9, 0,      0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,      1, 0, 1, 9, 'hC3,   0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,      1, 0, 0, 9, 0,      0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,      0, 0, 0, 0, 0,      0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Worst-case wait for port 0 while the loader locks continuously, starting with rr_ptr on port 1.
    @(negedge clk);
    rst_n = 1'b0; m0_req = 0; m1_req = 0; m1_lock = 0;
    @(negedge clk);
    rst_n = 1'b1; m0_req = 1; m0_we = 0; m0_addr = 1;
    @(negedge clk);
    m1_req = 1; m1_lock = 1; m1_we = 0; m1_addr = 9;
    denied = 0; nlocked = 0; seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      #1;
      if (m0_gnt) seen = 1'b1;
      else begin
        denied++;
        if (locked) nlocked++;
      end
      @(negedge clk);
    end
    chk("p0 wait granted", 32'(seen), 32'd1);
    chk("p0 wait cycles", 32'(denied), 32'(MAX_LOCK + 1));
    chk("lock span", 32'(nlocked), 32'(MAX_LOCK));
    m0_req = 0; m1_req = 0; m1_lock = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
